// File: rtl/data_mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
//   Shared types and constants for the data_mem arbiter slice.
//   - state_t : arbiter FSM states (IDLE -> ACCESS -> RESP -> IDLE)
//   - port_t  : identifies which requester owns the current command
//   - R_W_*   : data_mem r_w encodings
//   - DEF_*   : default address/data widths matching the 256x8 data_mem
// ---------------------------------------------------------------------------
package mem_arb_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;

  localparam logic R_W_WRITE = 1'b1;
  localparam logic R_W_READ  = 1'b0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_t;

endpackage

// File: rtl/data_mem_arbiter_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
//   Purely combinational two-way picker.
//   Ports:
//     req_a, req_b  : pending requests from port A / port B
//     last_winner   : port that won the most recent grant
//     grant_a/b     : one-hot (or zero) pick result
//   Parameter ROUND_ROBIN:
//     1 -> on conflict the port that did NOT win last time is picked
//     0 -> on conflict port A always wins (B may starve)
//   The picker never asserts both grants.
// ---------------------------------------------------------------------------
module rr_arb2
  import mem_arb_pkg::*;
#(
  parameter int ROUND_ROBIN = 1
) (
  input  logic  req_a,
  input  logic  req_b,
  input  port_t last_winner,
  output logic  grant_a,
  output logic  grant_b
);

  // A lone requester always wins. On a conflict, round-robin mode hands the
  // slot to whichever port lost last time; fixed-priority mode favours A.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (req_a && req_b) begin
      if ((ROUND_ROBIN != 0) && (last_winner == PORT_A)) begin
        grant_b = 1'b1;
      end else begin
        grant_a = 1'b1;
      end
    end else begin
      grant_a = req_a;
      grant_b = req_b;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// ---------------------------------------------------------------------------
// data_mem_arbiter
//   Shares the single-port data_mem between port A (CPU load/store unit) and
//   port B (DMA/loader). Arbitrates in IDLE, latches the winning command,
//   drives data_mem for one ACCESS cycle and, for reads, returns the data
//   with a one-cycle rvalid pulse in RESP.
//
//   Ports:
//     clk, rst                  : clock, synchronous active-high reset
//     a_req/a_we/a_addr/a_wdata : port A command (held until a_gnt)
//     a_gnt                     : A command accepted at this edge
//     a_rvalid/a_rdata          : A read return (rdata held until next A read)
//     b_*                       : identical set for port B
//     address_bus/data_in/r_w   : drive to data_mem
//     data_out                  : data_mem read data (combinational)
//
//   Timing: write grant at cycle 0, commit at end of cycle 1.
//           read grant at cycle 0, rvalid at cycle 2.
// ---------------------------------------------------------------------------
module data_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ROUND_ROBIN = 1
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,

  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,

  output logic [ADDR_W-1:0] address_bus,
  output logic [DATA_W-1:0] data_in,
  output logic              r_w,
  input  logic [DATA_W-1:0] data_out
);

  state_t            state;
  port_t             last_winner;
  port_t             cmd_port;
  logic              cmd_we;

  logic              pick_a;
  logic              pick_b;
  logic              grant_slot;

  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  rr_arb2 #(
    .ROUND_ROBIN (ROUND_ROBIN)
  ) u_rr_arb2 (
    .req_a       (a_req),
    .req_b       (b_req),
    .last_winner (last_winner),
    .grant_a     (pick_a),
    .grant_b     (pick_b)
  );

  // Grants can only be issued from IDLE, and never while reset is held,
  // so a requester sitting on req through reset sees no spurious accept.
  assign grant_slot = (state == IDLE) && !rst;
  assign a_gnt      = grant_slot && pick_a;
  assign b_gnt      = grant_slot && pick_b;

  // Steer the winning port's command fields toward the latch. When nobody
  // is picked the A fields pass through, but they are not latched then.
  always_comb begin
    sel_we    = a_we;
    sel_addr  = a_addr;
    sel_wdata = a_wdata;
    if (pick_b) begin
      sel_we    = b_we;
      sel_addr  = b_addr;
      sel_wdata = b_wdata;
    end
  end

  // Main FSM with registered data_mem drive and read-return outputs.
  // address_bus/data_in double as the command latch: they are loaded on the
  // grant edge, so they present the command throughout ACCESS and simply
  // hold afterwards. r_w is high only for the ACCESS cycle of a write, which
  // keeps data_mem safe from stray writes in every other cycle. A reset that
  // lands during a write ACCESS still lets the write commit because data_mem
  // samples r_w at the same edge; a read in flight is dropped without rvalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last_winner <= PORT_B;
      cmd_port    <= PORT_A;
      cmd_we      <= R_W_READ;
      address_bus <= '0;
      data_in     <= '0;
      r_w         <= R_W_READ;
      a_rvalid    <= 1'b0;
      b_rvalid    <= 1'b0;
      a_rdata     <= '0;
      b_rdata     <= '0;
    end else begin
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      case (state)
        IDLE: begin
          if (a_gnt || b_gnt) begin
            cmd_port    <= b_gnt ? PORT_B : PORT_A;
            last_winner <= b_gnt ? PORT_B : PORT_A;
            cmd_we      <= sel_we;
            address_bus <= sel_addr;
            data_in     <= sel_wdata;
            r_w         <= sel_we ? R_W_WRITE : R_W_READ;
            state       <= ACCESS;
          end
        end

        ACCESS: begin
          r_w <= R_W_READ;
          if (cmd_we == R_W_WRITE) begin
            state <= IDLE;
          end else begin
            if (cmd_port == PORT_A) begin
              a_rdata  <= data_out;
              a_rvalid <= 1'b1;
            end else begin
              b_rdata  <= data_out;
              b_rvalid <= 1'b1;
            end
            state <= RESP;
          end
        end

        RESP: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
          r_w   <= R_W_READ;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_data_mem_arbiter
//   Drives a round-robin arbiter and a fixed-priority arbiter from the same
//   requester queues, each with its own 256x8 data_mem model. A transaction
//   level reference (expected memory image, busy countdown, pending access
//   and response records) predicts every output of the round-robin instance
//   each cycle; the fixed-priority instance is checked in the starvation test.
// ---------------------------------------------------------------------------
module tb_data_mem_arbiter;

  localparam int AW = 8;
  localparam int DW = 8;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } cmd_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_next = 1'b1;

  always #5 clk = ~clk;

  logic          a_req, a_we, b_req, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;

  logic          a_gnt, a_rvalid, b_gnt, b_rvalid, r_w;
  logic [DW-1:0] a_rdata, b_rdata, data_in, data_out;
  logic [AW-1:0] address_bus;

  logic          fp_a_gnt, fp_a_rvalid, fp_b_gnt, fp_b_rvalid, fp_r_w;
  logic [DW-1:0] fp_a_rdata, fp_b_rdata, fp_data_in, fp_data_out;
  logic [AW-1:0] fp_address_bus;

  logic [DW-1:0] mem_rr [256] = '{default: 8'h00};
  logic [DW-1:0] mem_fp [256] = '{default: 8'h00};

  data_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ROUND_ROBIN(1)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .address_bus(address_bus), .data_in(data_in), .r_w(r_w), .data_out(data_out)
  );

  data_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ROUND_ROBIN(0)) dut_fp (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(fp_a_gnt), .a_rvalid(fp_a_rvalid), .a_rdata(fp_a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(fp_b_gnt), .b_rvalid(fp_b_rvalid), .b_rdata(fp_b_rdata),
    .address_bus(fp_address_bus), .data_in(fp_data_in), .r_w(fp_r_w), .data_out(fp_data_out)
  );

  // Behavioural data_mem for each arbiter: combinational read, write on edge.
  assign data_out    = mem_rr[address_bus];
  assign fp_data_out = mem_fp[fp_address_bus];

  always @(posedge clk) begin
    if (r_w) mem_rr[address_bus] <= data_in;
  end

  always @(posedge clk) begin
    if (fp_r_w) mem_fp[fp_address_bus] <= fp_data_in;
  end

  // Requester queues and reference model state.
  cmd_t          qa[$];
  cmd_t          qb[$];
  logic [DW-1:0] ref_mem [256] = '{default: 8'h00};
  int            busy_left;
  bit            acc_valid;
  bit            acc_we;
  int            acc_port;
  logic [AW-1:0] acc_addr;
  logic [DW-1:0] acc_data;
  bit            resp_valid;
  int            resp_port;
  logic [DW-1:0] exp_rdata [2];
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_din;
  int            last_win;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit fp_check = 0;
  int fp_k = 0;
  bit recording = 0;
  int gseq[$];

  // Fallback stop in case a loop ever misbehaves.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic modelReset();
    acc_valid    = 0;
    acc_we       = 0;
    acc_port     = 0;
    resp_valid   = 0;
    resp_port    = 0;
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
    exp_addr     = '0;
    exp_din      = '0;
    last_win     = 1;
    busy_left    = 0;
  endtask

  task automatic applyStimulus();
    rst = rst_next;
    if (qa.size() > 0) begin
      a_req = 1'b1; a_we = qa[0].we; a_addr = qa[0].addr; a_wdata = qa[0].wdata;
    end else begin
      a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
    end
    if (qb.size() > 0) begin
      b_req = 1'b1; b_we = qb[0].we; b_addr = qb[0].addr; b_wdata = qb[0].wdata;
    end else begin
      b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  function automatic cmd_t mkCmd(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    cmd_t c;
    c.we = we; c.addr = addr; c.wdata = wdata;
    return c;
  endfunction

  function automatic cmd_t randCmd();
    cmd_t c;
    c.we    = 1'($urandom_range(0, 1));
    c.addr  = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 15));
    c.wdata = 8'($urandom_range(0, 255));
    return c;
  endfunction

  // One clock cycle: drive at the falling edge, predict and compare just
  // after, then advance the reference to what the coming rising edge does.
  task automatic runCycle();
    bit   ga;
    bit   gb;
    cmd_t c;
    @(negedge clk);
    applyStimulus();
    #1;
    ga = 0;
    gb = 0;
    if (!rst && busy_left == 0) begin
      if (qa.size() > 0 && qb.size() > 0) begin
        if (last_win == 0) gb = 1; else ga = 1;
      end else begin
        ga = (qa.size() > 0);
        gb = (qb.size() > 0);
      end
    end

    checkOutput("a_gnt", 32'(a_gnt), 32'(ga));
    checkOutput("b_gnt", 32'(b_gnt), 32'(gb));
    checkOutput("gnt_exclusive", 32'(a_gnt & b_gnt), 32'(0));
    checkOutput("r_w", 32'(r_w), 32'(acc_valid && acc_we));
    checkOutput("address_bus", 32'(address_bus), 32'(exp_addr));
    checkOutput("data_in", 32'(data_in), 32'(exp_din));
    checkOutput("a_rvalid", 32'(a_rvalid), 32'(resp_valid && resp_port == 0));
    checkOutput("b_rvalid", 32'(b_rvalid), 32'(resp_valid && resp_port == 1));
    checkOutput("rvalid_exclusive", 32'(a_rvalid & b_rvalid), 32'(0));
    checkOutput("a_rdata", 32'(a_rdata), 32'(exp_rdata[0]));
    checkOutput("b_rdata", 32'(b_rdata), 32'(exp_rdata[1]));

    if (fp_check) begin
      checkOutput("fp_a_gnt", 32'(fp_a_gnt), 32'((fp_k % 3) == 0));
      checkOutput("fp_b_gnt", 32'(fp_b_gnt), 32'(0));
      fp_k++;
    end

    if (recording) begin
      if (a_gnt) gseq.push_back(0);
      if (b_gnt) gseq.push_back(1);
    end

    if (acc_valid && acc_we) ref_mem[acc_addr] = acc_data;
    if (rst) begin
      modelReset();
    end else begin
      resp_valid = acc_valid && !acc_we;
      if (resp_valid) begin
        resp_port = acc_port;
        exp_rdata[acc_port] = ref_mem[acc_addr];
      end
      if (ga || gb) begin
        if (gb) c = qb.pop_front(); else c = qa.pop_front();
        acc_valid = 1;
        acc_we    = c.we;
        acc_port  = gb ? 1 : 0;
        acc_addr  = c.addr;
        acc_data  = c.wdata;
        exp_addr  = c.addr;
        exp_din   = c.wdata;
        last_win  = acc_port;
        busy_left = c.we ? 1 : 2;
      end else begin
        acc_valid = 0;
        if (busy_left > 0) busy_left--;
      end
    end
    cyc++;
  endtask

  task automatic runUntilIdle(input string tag, input int max_cycles);
    int n = 0;
    while ((qa.size() > 0 || qb.size() > 0 || acc_valid || resp_valid || busy_left > 0) && n < max_cycles) begin
      runCycle();
      n++;
    end
    checkOutput(tag, 32'(n < max_cycles), 32'(1));
  endtask

  initial begin
    modelReset();
    applyStimulus();
    @(posedge clk);
    modelReset();

    $display("[TB] test 1: reset with requests pending");
    qa.push_back(mkCmd(1'b0, 8'h00, 8'h00));
    qb.push_back(mkCmd(1'b0, 8'h00, 8'h00));
    rst_next = 1'b1;
    runCycle();
    checkOutput("t1_no_gnt_in_reset", 32'(a_gnt | b_gnt), 32'(0));
    runCycle();
    checkOutput("t1_no_gnt_in_reset", 32'(a_gnt | b_gnt), 32'(0));
    rst_next = 1'b0;
    runCycle();
    checkOutput("t1_first_gnt_a", 32'(a_gnt), 32'(1));
    runUntilIdle("t1_drain", 50);

    $display("[TB] test 2: A write then read");
    qa.push_back(mkCmd(1'b1, 8'h00, 8'h01));
    qa.push_back(mkCmd(1'b0, 8'h00, 8'h00));
    runUntilIdle("t2_drain", 50);
    checkOutput("t2_a_rdata", 32'(a_rdata), 32'(8'h01));

    $display("[TB] test 3: both ports write then read back, top address");
    qb.push_back(mkCmd(1'b1, 8'h01, 8'h07));
    qa.push_back(mkCmd(1'b1, 8'hFF, 8'hAA));
    qb.push_back(mkCmd(1'b0, 8'h01, 8'h00));
    qa.push_back(mkCmd(1'b0, 8'hFF, 8'h00));
    runUntilIdle("t3_drain", 50);
    checkOutput("t3_b_rdata", 32'(b_rdata), 32'(8'h07));
    checkOutput("t3_a_rdata", 32'(a_rdata), 32'(8'hAA));

    $display("[TB] test 4: round-robin alternation under continuous reads");
    rst_next = 1'b1;
    runCycle();
    rst_next = 1'b0;
    for (int i = 0; i < 4; i++) begin
      qa.push_back(mkCmd(1'b0, 8'($urandom_range(0, 255)), 8'h00));
      qb.push_back(mkCmd(1'b0, 8'($urandom_range(0, 255)), 8'h00));
    end
    recording = 1;
    runUntilIdle("t4_drain", 100);
    recording = 0;
    checkOutput("t4_grant_count", 32'(gseq.size()), 32'(8));
    for (int i = 0; i < gseq.size() && i < 8; i++) begin
      checkOutput("t4_grant_order", 32'(gseq[i]), 32'(i % 2));
    end

    $display("[TB] test 5: fixed priority starves B");
    rst_next = 1'b1;
    runCycle();
    rst_next = 1'b0;
    for (int i = 0; i < 12; i++) begin
      qa.push_back(mkCmd(1'b0, 8'($urandom_range(0, 255)), 8'h00));
      qb.push_back(mkCmd(1'b0, 8'($urandom_range(0, 255)), 8'h00));
    end
    fp_check = 1;
    for (int i = 0; i < 12; i++) runCycle();
    fp_check = 0;
    runUntilIdle("t5_drain", 200);

    $display("[TB] test 6: reset during read and write access");
    qa.push_back(mkCmd(1'b0, 8'hFF, 8'h00));
    runCycle();
    checkOutput("t6_read_gnt", 32'(a_gnt), 32'(1));
    rst_next = 1'b1;
    runCycle();
    rst_next = 1'b0;
    for (int i = 0; i < 3; i++) runCycle();
    checkOutput("t6_a_rdata_cleared", 32'(a_rdata), 32'(0));
    qb.push_back(mkCmd(1'b1, 8'h10, 8'h5A));
    runCycle();
    checkOutput("t6_write_gnt", 32'(b_gnt), 32'(1));
    rst_next = 1'b1;
    runCycle();
    rst_next = 1'b0;
    qb.push_back(mkCmd(1'b0, 8'h10, 8'h00));
    runUntilIdle("t6_drain", 50);
    checkOutput("t6_write_survived_reset", 32'(b_rdata), 32'(8'h5A));

    $display("[TB] test 7: randomized traffic");
    for (int i = 0; i < 300; i++) begin
      if (qa.size() < 2 && $urandom_range(0, 2) == 0) qa.push_back(randCmd());
      if (qb.size() < 2 && $urandom_range(0, 2) == 0) qb.push_back(randCmd());
      rst_next = ($urandom_range(0, 59) == 0);
      runCycle();
    end
    rst_next = 1'b0;
    runUntilIdle("t7_drain", 100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
